// File: rtl/arm_arith_pkg.sv
// Shared parameters and state type for the multi-cycle wide-arithmetic blocks.
// Slice counts are derived from the operand widths so every user agrees on them.
package arm_arith_pkg;

  localparam int WA_DEF    = 56;
  localparam int WB_DEF    = 15;
  localparam int CHUNK_DEF = 8;

  function automatic int calc_nch(input int wa, input int chunk);
    return wa / chunk;
  endfunction

  function automatic int calc_bch(input int wb, input int chunk);
    return (wb + chunk - 1) / chunk;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_slice.sv
// Combinational W-bit ripple-borrow cell: diff = a - b - bin, bout set on underflow.
module subtractor_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] w_full;

  // One extra bit catches the sign of the slice result, i.e. the borrow out.
  assign w_full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff   = w_full[W-1:0];
  assign bout   = w_full[W];

endmodule

// File: rtl/custom_subtractor56_41.sv
// Multi-cycle A - zext(B), one CHUNK-bit slice per cycle from the LSB up,
// stopping as soon as the borrow dies above the subtrahend's slices.
module custom_subtractor56_41
  import arm_arith_pkg::*;
#(
  parameter int WA    = WA_DEF,
  parameter int WB    = WB_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] Diff,
  output logic          Borrow
);

  localparam int NCH  = calc_nch(WA, CHUNK);
  localparam int BCH  = calc_bch(WB, CHUNK);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IDXW-1:0]           r_idx;
  logic                      r_brw;
  logic                      r_borrow;
  logic [NCH-1:0][CHUNK-1:0] r_result;
  logic [NCH-1:0][CHUNK-1:0] r_sub;

  logic [CHUNK-1:0] w_a_cur;
  logic [CHUNK-1:0] w_b_cur;
  logic [CHUNK-1:0] w_diff;
  logic             w_bout;
  logic             w_past_b;
  logic             w_last;

  assign w_a_cur  = r_result[r_idx];
  assign w_b_cur  = r_sub[r_idx];
  assign w_past_b = (r_idx >= IDXW'(BCH - 1));
  assign w_last   = (r_idx == IDXW'(NCH - 1));

  subtractor_slice #(.W(CHUNK)) u_slice (
    .a   (w_a_cur),
    .b   (w_b_cur),
    .bin (r_brw),
    .diff(w_diff),
    .bout(w_bout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_next = RUN;
      // Once past B's slices with no borrow, the remaining slices already equal A.
      RUN: begin
        if ((w_past_b && !w_bout) || w_last) w_state_next = DONE;
      end
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_brw    <= 1'b0;
      r_borrow <= 1'b0;
      r_result <= '0;
      r_sub    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_result <= A;
            r_sub    <= {{(WA - WB){1'b0}}, B};
            r_idx    <= '0;
            r_brw    <= 1'b0;
            r_borrow <= 1'b0;
          end
        end
        RUN: begin
          r_result[r_idx] <= w_diff;
          r_brw           <= w_bout;
          r_idx           <= r_idx + IDXW'(1);
          // Early exit implies w_bout is 0, so this covers both exit paths.
          if (w_state_next == DONE) r_borrow <= w_bout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Diff      = r_result;
  assign Borrow    = r_borrow;

endmodule

// File: tb/tb_custom_subtractor56_41.sv
// Scoreboard bench: expected Diff/Borrow/latency queued at drive time, popped on out_valid.
module tb_custom_subtractor56_41;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] A;
  logic [14:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] Diff;
  logic        Borrow;

  typedef struct {
    logic [55:0] diff;
    logic        borrow;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  custom_subtractor56_41 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Borrow   (Borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slice k stops the run if the low (k+1) slices of A are not below those of B.
  function automatic int model_lat(input logic [55:0] a, input logic [14:0] b);
    logic [63:0] msk;
    for (int k = 1; k < 7; k++) begin
      msk = (64'd1 << (8 * (k + 1))) - 64'd1;
      if (!(({8'd0, a} & msk) < ({49'd0, b} & msk))) return k + 1;
    end
    return 7;
  endfunction

  task automatic do_op(input logic [55:0] a, input logic [14:0] b, input int hold);
    exp_t e;
    exp_t g;
    int   lat;
    logic [55:0] held_diff;
    logic        held_brw;
    @(negedge clk);
    check_val("in_ready_idle", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    e.diff    = a - {41'd0, b};
    e.borrow  = (a < {41'd0, b});
    e.lat     = model_lat(a, b);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = 15'($urandom);
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check_val("out_valid_timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    g = sb_q.pop_front();
    check_val("diff", {8'd0, Diff}, {8'd0, g.diff});
    check_val("borrow", {63'd0, Borrow}, {63'd0, g.borrow});
    check_val("latency", 64'(lat), 64'(g.lat));
    $display("op A=0x%014h B=0x%04h -> Diff=0x%014h Borrow=%0d lat=%0d",
             a, b, Diff, Borrow, lat);
    held_diff = Diff;
    held_brw  = Borrow;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = i[0];
      A        = {$urandom, $urandom} >> 8;
      B        = 15'($urandom);
      @(posedge clk);
      #1;
      check_val("hold_valid", {63'd0, out_valid}, 64'd1);
      check_val("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("hold_diff", {8'd0, Diff}, {8'd0, held_diff});
      check_val("hold_borrow", {63'd0, Borrow}, {63'd0, held_brw});
    end
    // in_valid high across the output handshake must not be taken on the same edge.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A         = 56'hABCDEF;
    @(posedge clk);
    #1;
    check_val("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_diff", {8'd0, Diff}, 64'd0);
    check_val("rst_borrow", {63'd0, Borrow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(56'd100, 15'd1, 0);
    do_op(56'd0, 15'd1, 0);
    do_op(56'h80_0000_0000_0000, 15'h7FFF, 0);
    do_op(56'h100, 15'h1, 0);
    do_op(56'h12_3456_789A_BCDE, 15'd0, 0);
    do_op(56'h7ABC, 15'h7ABC, 0);
    do_op(56'h00_0000_0000_0005, 15'h7FFF, 10);
    for (int n = 0; n < 8; n++) begin
      logic [55:0] ra;
      ra = {$urandom, $urandom} >> 8;
      if (n[0]) ra = ra & 56'hFF_FFFF;
      do_op(ra, 15'($urandom), 0);
    end

    // Reset while RUN sits at slice index 3 of a long borrow ripple.
    @(negedge clk);
    in_valid = 1'b1;
    A        = 56'd0;
    B        = 15'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_val("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("midrun_rst_diff", {8'd0, Diff}, 64'd0);
    check_val("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("midrun_rst_borrow", {63'd0, Borrow}, 64'd0);
    $display("reset pulse mid-RUN: out_valid=%0d Diff=0x%014h", out_valid, Diff);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(56'd5, 15'd5, 0);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
